i2c_eeprom_responder: RTL
=========================

Name: i2c_eeprom_responder

Overview:
Synthesizable I2C target that emulates a 24C02-class EEPROM (256 x 8) at 7-bit address 7'b1010000. It sits on the io_I2C_SCL/io_I2C_SDA bus opposite the I2C master, as a loop-back peer on-board and as a DUT-side responder in simulation. It oversamples the bus on the 10 MHz clock, decodes START/STOP, ACKs its own address, and supports register-address set, byte/sequential write, and current/random/sequential read.

Parameters:
CHIP_ADDR, 7'b1010000, 7-bit target address matched against the first byte after START
MEM_INIT, 8'h00, value loaded into every memory location at reset
SYNC_STAGES, 2, flip-flop stages on SCL and SDA inputs (minimum 2)

Ports:
o_clk10MHz  input  1  system clock; all logic on rising edge
i_RST_n  input  1  asynchronous, active-low reset
io_I2C_SCL  input  1  bus clock from master; never driven by this block (no clock stretching)
io_I2C_SDA  inout  1  open-drain data; driven 1'b0 or 1'bz only
o_Busy  output  1  high from a START matching CHIP_ADDR until STOP or NACK-terminated read
o_Wr_Strobe  output  1  one-cycle pulse per data byte written to memory
o_Cur_Addr  output  8  internal word-address pointer
o_Last_Wr_Data  output  8  last byte written to memory

Behaviour:
- Reset: all outputs 0, SDA released (z), state IDLE, pointer 8'h00, memory = MEM_INIT.
- Input sync: SCL/SDA pass through SYNC_STAGES FFs; edges detected on synced values (1 extra cycle of delay).
- START = SDA falling while SCL high; STOP = SDA rising while SCL high. Both are detected in any state.
- START in any state (repeated START included) -> ADDR; bit counter cleared; SDA released.
- STOP in any state -> IDLE; SDA released; o_Busy=0; pointer retained.
- Data sampled on synced SCL rising edge, MSB first. SDA output changes only on the cycle after a synced SCL falling edge.
- States:
  IDLE: waits for START.
  ADDR: shifts 8 bits. If [7:1]==CHIP_ADDR -> ADDR_ACK, o_Busy=1. Otherwise -> IDLE and SDA is never driven (NACK).
  ADDR_ACK: SDA low for the 9th clock. Then R/W=0 -> REG; R/W=1 -> RD_DATA (pointer byte preloaded into shift register).
  REG: 8 bits -> pointer loaded -> REG_ACK (ACK) -> WR_DATA.
  WR_DATA: 8 bits -> mem[pointer] written, o_Wr_Strobe pulsed, o_Last_Wr_Data updated, pointer+1 -> WR_ACK (ACK) -> WR_DATA.
  RD_DATA: drives mem[pointer] bits (0 -> drive low, 1 -> z). After the 8th bit, pointer+1 -> RD_ACK.
  RD_ACK: releases SDA and samples the master's 9th bit. 0 (ACK) -> RD_DATA with next byte; 1 (NACK) -> WAIT_STOP with o_Busy=0.
  WAIT_STOP: ignores SCL and waits for START/STOP.
- Pointer is 8-bit and wraps 8'hFF -> 8'h00 on both read and write; there is no page boundary.
- A write commits only when the full 8th bit is sampled. A STOP/START mid-byte discards the partial byte and leaves memory and pointer unchanged.
- The ACK drive window runs from the SCL falling edge after bit 8 to the SCL falling edge after bit 9.
- Reset asserted mid-transfer: SDA released immediately (asynchronous), memory reinitialised.

Decomposition:
- Shared package i2c_defs: state encodings, CHIP_ADDR default, bit-count width, and the R/W polarity constants matching the master's Read/Write flags.
- One sub-module i2c_bus_sync_edge: synchronizer plus SCL rise/fall and START/STOP detection, reusable by the master.

Test Plan:
- Byte write: START, 0xA0, 0x80, 0xAA, STOP -> three ACKs; mem[0x80]=0xAA; o_Wr_Strobe pulses once; o_Last_Wr_Data=0xAA; o_Cur_Addr=0x81.
- Random read: START, 0xA0, 0x80, repeated START, 0xA1, master NACK, STOP -> byte read is 0xAA; o_Busy falls after the NACK; o_Cur_Addr=0x81.
- Address mismatch: START, 0xA2, ... -> SDA never driven low during the transaction; no memory change; o_Busy stays 0.
- Sequential wrap: write 0x11, 0x22 starting at pointer 0xFF -> mem[0xFF]=0x11, mem[0x00]=0x22; a sequential read from 0xFF returns 0x11, 0x22.
- Abort: STOP after 4 bits of a data byte -> memory unchanged, state IDLE, SDA z; the next START/0xA0 is ACKed normally.
- Reset mid-ACK: assert i_RST_n low while driving ACK -> SDA z within the same cycle; all outputs 0; mem[0x80]=MEM_INIT.

Source files
------------

// File: rtl/i2c_defs.sv
// Shared I2C definitions: responder state encoding, default target address,
// bit-counter sizing and the R/W flag polarity used by master and responder.
package i2c_defs;

    localparam logic [6:0] CHIP_ADDR_DEFAULT = 7'b1010000;
    localparam int         MEM_DEPTH         = 256;
    localparam int         BIT_CNT_W         = 4;

    localparam logic [BIT_CNT_W-1:0] BIT_ONE  = BIT_CNT_W'(1);
    localparam logic [BIT_CNT_W-1:0] BIT_LAST = BIT_CNT_W'(7);
    localparam logic [BIT_CNT_W-1:0] BIT_DONE = BIT_CNT_W'(8);

    localparam logic RW_WRITE = 1'b0;
    localparam logic RW_READ  = 1'b1;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_REG,
        ST_REG_ACK,
        ST_WR_DATA,
        ST_WR_ACK,
        ST_RD_DATA,
        ST_RD_ACK,
        ST_WAIT_STOP
    } resp_state_t;

endpackage

// File: rtl/i2c_bus_sync_edge.sv
// Synchronises SCL/SDA into the local clock and flags SCL edges plus
// START/STOP conditions from the synchronised levels.
module i2c_bus_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic o_clk10MHz,
    input  logic i_RST_n,
    input  logic scl_in,
    input  logic sda_in,
    output logic sda,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det
);

    logic [SYNC_STAGES-1:0] scl_sync_reg;
    logic [SYNC_STAGES-1:0] sda_sync_reg;
    logic                   scl_d_reg;
    logic                   sda_d_reg;
    logic                   scl;

    // Idle bus is high, so reset to 1 to avoid a phantom edge on release.
    always_ff @(posedge o_clk10MHz or negedge i_RST_n) begin
        if (!i_RST_n) begin
            scl_sync_reg <= '1;
            sda_sync_reg <= '1;
            scl_d_reg    <= 1'b1;
            sda_d_reg    <= 1'b1;
        end else begin
            scl_sync_reg <= {scl_sync_reg[SYNC_STAGES-2:0], scl_in};
            sda_sync_reg <= {sda_sync_reg[SYNC_STAGES-2:0], sda_in};
            scl_d_reg    <= scl;
            sda_d_reg    <= sda;
        end
    end

    assign scl       = scl_sync_reg[SYNC_STAGES-1];
    assign sda       = sda_sync_reg[SYNC_STAGES-1];
    assign scl_rise  = scl & ~scl_d_reg;
    assign scl_fall  = ~scl & scl_d_reg;
    assign start_det = scl & scl_d_reg & sda_d_reg & ~sda;
    assign stop_det  = scl & scl_d_reg & ~sda_d_reg & sda;

endmodule

// File: rtl/i2c_eeprom_responder.sv
// I2C target emulating a 256 x 8 EEPROM: address ACK, word-pointer set,
// sequential write and sequential read with an 8-bit wrapping pointer.
module i2c_eeprom_responder
    import i2c_defs::*;
#(
    parameter logic [6:0] CHIP_ADDR   = CHIP_ADDR_DEFAULT,
    parameter logic [7:0] MEM_INIT    = 8'h00,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       o_clk10MHz,
    input  logic       i_RST_n,
    input  logic       io_I2C_SCL,
    inout  wire        io_I2C_SDA,
    output logic       o_Busy,
    output logic       o_Wr_Strobe,
    output logic [7:0] o_Cur_Addr,
    output logic [7:0] o_Last_Wr_Data
);

    logic sda, scl_rise, scl_fall, start_det, stop_det;

    i2c_bus_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .o_clk10MHz (o_clk10MHz),
        .i_RST_n    (i_RST_n),
        .scl_in     (io_I2C_SCL),
        .sda_in     (io_I2C_SDA),
        .sda        (sda),
        .scl_rise   (scl_rise),
        .scl_fall   (scl_fall),
        .start_det  (start_det),
        .stop_det   (stop_det)
    );

    resp_state_t          state_reg, state_next;
    logic [BIT_CNT_W-1:0] bit_cnt_reg, bit_cnt_next;
    logic [7:0]           shift_reg, shift_next;
    logic [7:0]           ptr_reg, ptr_next;
    logic                 sda_low_reg, sda_low_next;
    logic                 busy_reg, busy_next;
    logic                 rw_reg, rw_next;
    logic                 wr_strobe_reg;
    logic [7:0]           last_wr_reg;
    logic [7:0]           mem [MEM_DEPTH];
    logic                 mem_we;
    logic [7:0]           rx_byte;
    logic [7:0]           rd_byte;

    always_ff @(posedge o_clk10MHz or negedge i_RST_n) begin
        if (!i_RST_n) begin
            state_reg     <= ST_IDLE;
            bit_cnt_reg   <= '0;
            shift_reg     <= '0;
            ptr_reg       <= '0;
            sda_low_reg   <= 1'b0;
            busy_reg      <= 1'b0;
            rw_reg        <= RW_WRITE;
            wr_strobe_reg <= 1'b0;
            last_wr_reg   <= '0;
            for (int i = 0; i < MEM_DEPTH; i++) mem[i] <= MEM_INIT;
        end else begin
            state_reg     <= state_next;
            bit_cnt_reg   <= bit_cnt_next;
            shift_reg     <= shift_next;
            ptr_reg       <= ptr_next;
            sda_low_reg   <= sda_low_next;
            busy_reg      <= busy_next;
            rw_reg        <= rw_next;
            wr_strobe_reg <= mem_we;
            if (mem_we) begin
                mem[ptr_reg] <= rx_byte;
                last_wr_reg  <= rx_byte;
            end
        end
    end

    always_comb begin
        state_next   = state_reg;
        bit_cnt_next = bit_cnt_reg;
        shift_next   = shift_reg;
        ptr_next     = ptr_reg;
        sda_low_next = sda_low_reg;
        busy_next    = busy_reg;
        rw_next      = rw_reg;
        mem_we       = 1'b0;
        rx_byte      = {shift_reg[6:0], sda};
        rd_byte      = mem[ptr_reg];

        if (stop_det) begin
            state_next   = ST_IDLE;
            bit_cnt_next = '0;
            sda_low_next = 1'b0;
            busy_next    = 1'b0;
        end else if (start_det) begin
            state_next   = ST_ADDR;
            bit_cnt_next = '0;
            sda_low_next = 1'b0;
        end else begin
            case (state_reg)
                ST_ADDR: if (scl_rise) begin
                    shift_next   = rx_byte;
                    bit_cnt_next = bit_cnt_reg + BIT_ONE;
                    if (bit_cnt_reg == BIT_LAST) begin
                        bit_cnt_next = '0;
                        if (rx_byte[7:1] == CHIP_ADDR) begin
                            state_next = ST_ADDR_ACK;
                            busy_next  = 1'b1;
                            rw_next    = rx_byte[0];
                        end else begin
                            state_next = ST_IDLE;
                            busy_next  = 1'b0;
                        end
                    end
                end
                // First fall starts the ACK pulse, second fall ends it.
                ST_ADDR_ACK, ST_REG_ACK, ST_WR_ACK: if (scl_fall) begin
                    if (!sda_low_reg) begin
                        sda_low_next = 1'b1;
                    end else if (state_reg == ST_ADDR_ACK && rw_reg == RW_READ) begin
                        state_next   = ST_RD_DATA;
                        shift_next   = rd_byte;
                        sda_low_next = ~rd_byte[7];
                    end else begin
                        sda_low_next = 1'b0;
                        state_next   = (state_reg == ST_ADDR_ACK) ? ST_REG : ST_WR_DATA;
                    end
                end
                ST_REG, ST_WR_DATA: if (scl_rise) begin
                    shift_next   = rx_byte;
                    bit_cnt_next = bit_cnt_reg + BIT_ONE;
                    if (bit_cnt_reg == BIT_LAST) begin
                        bit_cnt_next = '0;
                        if (state_reg == ST_REG) begin
                            ptr_next   = rx_byte;
                            state_next = ST_REG_ACK;
                        end else begin
                            mem_we     = 1'b1;
                            ptr_next   = ptr_reg + 8'd1;
                            state_next = ST_WR_ACK;
                        end
                    end
                end
                ST_RD_DATA: begin
                    if (scl_rise) begin
                        bit_cnt_next = bit_cnt_reg + BIT_ONE;
                    end else if (scl_fall) begin
                        if (bit_cnt_reg == BIT_DONE) begin
                            bit_cnt_next = '0;
                            sda_low_next = 1'b0;
                            ptr_next     = ptr_reg + 8'd1;
                            state_next   = ST_RD_ACK;
                        end else begin
                            shift_next   = {shift_reg[6:0], 1'b0};
                            sda_low_next = ~shift_reg[6];
                        end
                    end
                end
                // bit_cnt marks that the master ACKed and the next byte is due.
                ST_RD_ACK: begin
                    if (scl_rise) begin
                        if (sda) begin
                            state_next = ST_WAIT_STOP;
                            busy_next  = 1'b0;
                        end else begin
                            bit_cnt_next = BIT_ONE;
                        end
                    end else if (scl_fall && bit_cnt_reg == BIT_ONE) begin
                        bit_cnt_next = '0;
                        state_next   = ST_RD_DATA;
                        shift_next   = rd_byte;
                        sda_low_next = ~rd_byte[7];
                    end
                end
                default: ;
            endcase
        end
    end

    assign io_I2C_SDA     = sda_low_reg ? 1'b0 : 1'bz;
    assign o_Busy         = busy_reg;
    assign o_Wr_Strobe    = wr_strobe_reg;
    assign o_Cur_Addr     = ptr_reg;
    assign o_Last_Wr_Data = last_wr_reg;

endmodule
